// File: rtl/xg_lsu_hs.sv
// xg_lsu_hs: load/store unit memory-stage handshake.
// Accepts one aligned load/store in IDLE, drives a registered memory request
// through BUSY until ack or timeout, then reports the result for one DONE cycle.
module xg_lsu_hs #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                stall,
   output logic [XLEN-1:0]     rdata,
   output logic                rdata_valid,
   output logic                misalign,
   output logic                bus_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic                mem_ack,
   input  logic [XLEN-1:0]     mem_rdata
);

   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CNTW = 16;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, stateNext;
   logic [CNTW-1:0]     toCnt;
   logic                toHit;
   logic                errFlag;
   logic [1:0]          capSize;
   logic                capUns;
   logic [OFFW-1:0]     capOff;
   logic                badReq;
   logic [NB-1:0]       beNew;
   logic [XLEN-1:0]     wdataNew;
   logic [XLEN-1:0]     laneData;
   logic [XLEN-1:0]     loadRes;
   logic [XLEN-1:0]     rdataReg;
   logic                memReqReg, memWeReg;
   logic [ADDR_W-1:0]   memAddrReg;
   logic [XLEN-1:0]     memWdataReg;
   logic [NB-1:0]       memBeReg;

   assign toHit = (toCnt == CNTW'(TIMEOUT - 1));

   // Alignment check on the incoming request; dword is illegal on a 32-bit datapath
   always_comb begin
      badReq = 1'b0;
      case (req_size)
         2'b00:   badReq = 1'b0;
         2'b01:   badReq = req_addr[0];
         2'b10:   badReq = (req_addr[1:0] != 2'b00);
         default: badReq = (XLEN == 32) || (req_addr[2:0] != 3'b000);
      endcase
   end

   // Store lane placement: data replicated across all lanes, byte enables select the addressed lane(s)
   always_comb begin
      beNew    = '0;
      wdataNew = req_wdata;
      case (req_size)
         2'b00: begin
            beNew    = NB'(1) << req_addr[OFFW-1:0];
            wdataNew = {NB{req_wdata[7:0]}};
         end
         2'b01: begin
            beNew    = NB'(3) << req_addr[OFFW-1:0];
            wdataNew = {(NB/2){req_wdata[15:0]}};
         end
         2'b10: begin
            beNew    = NB'(15) << req_addr[OFFW-1:0];
            wdataNew = {(NB/4){req_wdata[31:0]}};
         end
         default: begin
            beNew    = '1;
            wdataNew = req_wdata;
         end
      endcase
   end

   // Load extraction: shift addressed lane down, then zero/sign-extend by captured size
   always_comb begin
      laneData = mem_rdata >> {capOff, 3'b000};
      loadRes  = laneData;
      case (capSize)
         2'b00:   loadRes = capUns ? XLEN'(laneData[7:0])  : XLEN'($signed(laneData[7:0]));
         2'b01:   loadRes = capUns ? XLEN'(laneData[15:0]) : XLEN'($signed(laneData[15:0]));
         2'b10:   loadRes = capUns ? XLEN'(laneData[31:0]) : XLEN'($signed(laneData[31:0]));
         default: loadRes = laneData;
      endcase
   end

   // Next-state and combinational handshake outputs
   always_comb begin
      stateNext = state;
      stall     = 1'b0;
      misalign  = 1'b0;
      case (state)
         IDLE: begin
            // reset gates the request so nothing looks accepted in the reset cycle
            if (req_valid && !reset) begin
               if (badReq) begin
                  misalign = 1'b1;
               end else begin
                  stall     = 1'b1;
                  stateNext = BUSY;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (mem_ack || toHit) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // State register, request capture, timeout counter and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         toCnt       <= '0;
         errFlag     <= 1'b0;
         rdataReg    <= '0;
         memReqReg   <= 1'b0;
         memWeReg    <= 1'b0;
         memBeReg    <= '0;
         memAddrReg  <= '0;
         memWdataReg <= '0;
         capSize     <= 2'b00;
         capUns      <= 1'b0;
         capOff      <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (stateNext == BUSY) begin
                  memReqReg   <= 1'b1;
                  memWeReg    <= req_we;
                  memAddrReg  <= req_addr & ~ADDR_W'(NB - 1);
                  memWdataReg <= wdataNew;
                  memBeReg    <= beNew;
                  capSize     <= req_size;
                  capUns      <= req_unsigned;
                  capOff      <= req_addr[OFFW-1:0];
                  toCnt       <= '0;
                  errFlag     <= 1'b0;
               end
            end
            BUSY: begin
               if (mem_ack || toHit) begin
                  memReqReg <= 1'b0;
                  memWeReg  <= 1'b0;
                  memBeReg  <= '0;
                  errFlag   <= !mem_ack;
                  rdataReg  <= (mem_ack && !memWeReg) ? loadRes : '0;
               end else begin
                  toCnt <= toCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rdata       = rdataReg;
   assign rdata_valid = (state == DONE);
   assign bus_err     = (state == DONE) && errFlag;
   assign mem_req     = memReqReg;
   assign mem_we      = memWeReg;
   assign mem_addr    = memAddrReg;
   assign mem_wdata   = memWdataReg;
   assign mem_be      = memBeReg;

endmodule

// File: doc/xg_lsu_hs.md
XG_LSU_HS -- requirements
Module: xg_lsu_hs

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning maximum BUSY cycles before bus error; legal range is 1..65535.
REQ-004 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, width 1: memory-stage load/store present.
REQ-007 The block SHALL have port req_we, input, width 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, width 2: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 The block SHALL have port req_unsigned, input, width 1: load zero-extend when 1, sign-extend when 0.
REQ-010 The block SHALL have port req_addr, input, width ADDR_W: byte address.
REQ-011 The block SHALL have port req_wdata, input, width XLEN: store data, right-aligned.
REQ-012 The block SHALL have port stall, output, width 1: hold the pipeline.
REQ-013 The block SHALL have port rdata, output, width XLEN: extended load result.
REQ-014 The block SHALL have port rdata_valid, output, width 1: rdata valid and access complete.
REQ-015 The block SHALL have port misalign, output, width 1: access rejected as misaligned or illegal.
REQ-016 The block SHALL have port bus_err, output, width 1: memory timeout.
REQ-017 The block SHALL have port mem_req, output, width 1: memory request.
REQ-018 The block SHALL have port mem_we, output, width 1: memory write.
REQ-019 The block SHALL have port mem_addr, output, width ADDR_W: word-aligned address, low log2(XLEN/8) bits zero.
REQ-020 The block SHALL have port mem_wdata, output, width XLEN: lane-shifted store data.
REQ-021 The block SHALL have port mem_be, output, width XLEN/8: byte enables.
REQ-022 The block SHALL have port mem_ack, input, width 1: memory completion, one cycle.
REQ-023 The block SHALL have port mem_rdata, input, width XLEN: full-word read data, valid with mem_ack.

Function
REQ-024 The FSM SHALL have states IDLE, BUSY and DONE, and SHALL leave reset in IDLE.
REQ-025 In IDLE, a request with req_valid=1 that is aligned and legal SHALL be captured (addr, size, we, unsigned, wdata shifted into lanes, be), stall=1 in that cycle, and the next state SHALL be BUSY.
REQ-026 A request SHALL be misaligned when half has addr[0]≠0, word has addr[1:0]≠0, dword has addr[2:0]≠0, or size=11 with XLEN=32.
REQ-027 A misaligned request in IDLE SHALL produce misalign=1 combinationally, stall=0, no memory access, store suppressed, and the state SHALL remain IDLE.
REQ-028 mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be registered and SHALL be held constant throughout BUSY.
REQ-029 mem_req SHALL be 1 exactly while in BUSY.
REQ-030 In BUSY, stall SHALL be 1.
REQ-031 In BUSY, mem_ack=1 SHALL capture the load result and transition to DONE.
REQ-032 Each BUSY cycle without ack SHALL increment a timeout counter; at count TIMEOUT-1 without ack, the block SHALL go to DONE with bus_err=1 and rdata=0.
REQ-033 In DONE, rdata_valid SHALL be 1 for exactly 1 cycle, stall SHALL be 0, no new request SHALL be accepted, and the next state SHALL be IDLE.
REQ-034 Load extraction SHALL select the lane by addr low bits, then zero- or sign-extend by size and req_unsigned; a dword load SHALL pass through the full word.
REQ-035 Store lanes SHALL be: byte wdata[7:0] replicated to the addressed lane with one mem_be bit; half uses two bits; word uses four bits; dword uses all bits.
REQ-036 For stores, rdata SHALL be 0 and rdata_valid SHALL still pulse in DONE.
REQ-037 mem_ack outside BUSY SHALL be ignored.
REQ-038 Minimum latency SHALL be: request in cycle 0, mem_req in cycle 1, ack in cycle 1, DONE in cycle 2; stall is high in cycles 0-1.

Reset
REQ-039 Reset SHALL force IDLE, clear the timeout counter, and drive stall, rdata_valid, misalign, bus_err, mem_req, mem_we, mem_be and rdata to 0 on the next edge.
REQ-040 Reset in BUSY SHALL abandon the access, and a later ack SHALL be ignored.

Verification
REQ-041 The bench SHALL cover: load byte signed at addr 0x103, mem_rdata 0x80FF_0000, ack after 3 cycles -> rdata 0xFFFF_FF80, rdata_valid pulses once, stall high 4 cycles.
REQ-042 The bench SHALL cover: store half wdata 0x1234 at 0x202 -> mem_addr 0x200, mem_be 1100, mem_wdata[31:16]=0x1234, mem_we=1.
REQ-043 The bench SHALL cover: load word at 0x101 -> misalign=1, stall=0, mem_req stays 0.
REQ-044 The bench SHALL cover: TIMEOUT=4 with no ack -> bus_err with rdata_valid after 4 BUSY cycles, then IDLE.
REQ-045 The bench SHALL cover: reset asserted in the 2nd BUSY cycle, ack in the following cycle -> IDLE, rdata_valid never asserted.
REQ-046 The bench SHALL cover: XLEN=64, load dword at 0x8 with ack -> rdata equals mem_rdata, and size=11 at 0x4 -> misalign=1.
